// File: rtl/fetch_unit.sv
// Purpose: program counter, next-PC select (PC+1 / branch / jump) and boot/stall/halt sequencing.
// Latency: new PC is on address_imem one cycle after its commit edge; instruction fetch adds no delay.
// Backpressure: stall=1 holds the current PC and instruction live (no commit) until released.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   q_imem               instruction word for address_imem (same cycle)
//   BR, br_cond, JP      branch flag, ALU branch condition, jump flag (sampled on commit only)
//   stall                hold the current instruction
//   address_imem         current PC (registered)
//   pc_plus1             PC+1 modulo 2^PC_WIDTH (jal link value)
//   instr_valid          q_imem is a live instruction this cycle
//   halted               core stopped on a jump-to-self
//   instr_count          saturating committed-instruction count
module fetch_unit #(
  parameter int unsigned PC_WIDTH  = 12,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned BOOT_ADDR = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          q_imem,
  input  logic                 BR,
  input  logic                 br_cond,
  input  logic                 JP,
  input  logic                 stall,
  output logic [PC_WIDTH-1:0]  address_imem,
  output logic [PC_WIDTH-1:0]  pc_plus1,
  output logic                 instr_valid,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [PC_WIDTH-1:0] BOOT_PC = PC_WIDTH'(BOOT_ADDR);

  state_t                      state;
  logic [PC_WIDTH-1:0]         pc;
  logic [PC_WIDTH-1:0]         jp_target;
  logic [PC_WIDTH-1:0]         br_target;
  logic [PC_WIDTH-1:0]         next_pc;
  logic signed [PC_WIDTH+16:0] imm_sx;
  logic                        commit;
  logic                        jp_halt;
  logic                        unused_bits;

  assign address_imem = pc;
  assign pc_plus1     = pc + 1'b1;

  // Sign-extend the 17-bit offset to at least PC_WIDTH bits; only the low
  // PC_WIDTH bits matter because the branch target wraps modulo 2^PC_WIDTH.
  assign imm_sx    = $signed(q_imem[16:0]);
  assign br_target = pc_plus1 + imm_sx[PC_WIDTH-1:0];
  assign jp_target = q_imem[PC_WIDTH-1:0];

  // Jump outranks branch, so a jump with BR also set ignores br_cond.
  always_comb begin
    next_pc = pc_plus1;
    if (JP) begin
      next_pc = jp_target;
    end else if (BR && br_cond) begin
      next_pc = br_target;
    end
  end

  assign commit  = ((state == S_RUN) || (state == S_STALL)) && !stall;
  assign jp_halt = JP && (jp_target == pc);

  assign unused_bits = ^{q_imem[31:17], imm_sx[PC_WIDTH+16:PC_WIDTH]};

  // instr_valid/halted are registered alongside state so they depend on
  // state only, never combinationally on q_imem.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_BOOT;
      pc          <= BOOT_PC;
      instr_count <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          state       <= S_RUN;
          instr_valid <= 1'b1;
        end
        S_RUN, S_STALL: begin
          if (!commit) begin
            state <= S_STALL;
          end else begin
            pc <= next_pc;
            if (instr_count != '1) begin
              instr_count <= instr_count + 1'b1;
            end
            if (jp_halt) begin
              state       <= S_HALT;
              instr_valid <= 1'b0;
              halted      <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state       <= S_BOOT;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic [31:0] q_imem;
  logic        BR;
  logic        br_cond;
  logic        JP;
  logic        stall;
  logic [11:0] address_imem;
  logic [11:0] pc_plus1;
  logic        instr_valid;
  logic        halted;
  logic [31:0] instr_count;

  fetch_unit #(
    .PC_WIDTH (12),
    .CNT_WIDTH(32),
    .BOOT_ADDR(0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .q_imem      (q_imem),
    .BR          (BR),
    .br_cond     (br_cond),
    .JP          (JP),
    .stall       (stall),
    .address_imem(address_imem),
    .pc_plus1    (pc_plus1),
    .instr_valid (instr_valid),
    .halted      (halted),
    .instr_count (instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] pc;
    logic        valid;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: 0=BOOT 1=RUN 2=STALL 3=HALT
  int          m_state = 0;
  logic [11:0] m_pc    = '0;
  logic [31:0] m_cnt   = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic drive(input logic r, input logic br, input logic bc, input logic jp,
                       input logic st, input logic [31:0] q);
    reset   = r;
    BR      = br;
    br_cond = bc;
    JP      = jp;
    stall   = st;
    q_imem  = q;
  endtask

  // Advance the reference by one edge, push its expectation, clock the DUT,
  // then pop and compare against the DUT outputs.
  task automatic tick();
    exp_t        e;
    exp_t        g;
    logic [11:0] tgt;
    int          off;
    if (reset) begin
      m_state = 0;
      m_pc    = '0;
      m_cnt   = '0;
    end else begin
      case (m_state)
        0: m_state = 1;
        1, 2: begin
          if (stall) begin
            m_state = 2;
          end else begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            m_state = 1;
            if (JP) begin
              tgt = q_imem[11:0];
              if (tgt == m_pc) m_state = 3;
              m_pc = tgt;
            end else if (BR && br_cond) begin
              off  = $signed(q_imem[16:0]);
              m_pc = 12'(int'(m_pc) + 1 + off);
            end else begin
              m_pc = m_pc + 12'd1;
            end
          end
        end
        default: ;
      endcase
    end
    e.pc     = m_pc;
    e.valid  = (m_state == 1) || (m_state == 2);
    e.halted = (m_state == 3);
    e.cnt    = m_cnt;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      chk("pc",       {20'd0, address_imem}, {20'd0, g.pc});
      chk("pc_plus1", {20'd0, pc_plus1},     {20'd0, 12'(g.pc + 12'd1)});
      chk("valid",    {31'd0, instr_valid},  {31'd0, g.valid});
      chk("halted",   {31'd0, halted},       {31'd0, g.halted});
      chk("count",    instr_count,           g.cnt);
    end
  endtask

  task automatic jump_to(input logic [11:0] a);
    drive(0, 0, 0, 1, 0, {20'd0, a});
    tick();
  endtask

  logic [31:0] cnt_before;

  initial begin
    drive(1, 0, 0, 0, 0, 32'd0);
    @(negedge clock);

    // Reset then idle: PC 0,0,1,2,3 and count 3 after the fifth edge.
    tick();
    chk("rst_pc",     {20'd0, address_imem}, 32'd0);
    chk("rst_valid",  {31'd0, instr_valid},  32'd0);
    chk("rst_halted", {31'd0, halted},       32'd0);
    chk("rst_count",  instr_count,           32'd0);
    drive(0, 0, 0, 0, 0, 32'd0);
    tick();
    chk("boot_pc",    {20'd0, address_imem}, 32'd0);
    chk("boot_valid", {31'd0, instr_valid},  32'd1);
    tick();
    tick();
    tick();
    chk("seq_pc3",    {20'd0, address_imem}, 32'd3);
    chk("seq_cnt3",   instr_count,           32'd3);

    // Backward branch taken, then not taken.
    jump_to(12'd10);
    drive(0, 1, 1, 0, 0, 32'h0001_FFFD);
    tick();
    chk("br_taken_pc", {20'd0, address_imem}, 32'd8);
    jump_to(12'd10);
    drive(0, 1, 0, 0, 0, 32'h0001_FFFD);
    tick();
    chk("br_not_taken_pc", {20'd0, address_imem}, 32'd11);

    // PC wrap and branch wrap.
    jump_to(12'd4095);
    chk("pc_plus1_wrap", {20'd0, pc_plus1}, 32'd0);
    drive(0, 0, 0, 0, 0, 32'd0);
    tick();
    chk("pc_wrap", {20'd0, address_imem}, 32'd0);
    jump_to(12'd4090);
    drive(0, 1, 1, 0, 0, 32'd10);
    tick();
    chk("br_wrap_pc", {20'd0, address_imem}, 32'd5);

    // Stall for 3 cycles with a pending jump, then release.
    jump_to(12'd20);
    cnt_before = instr_count;
    drive(0, 0, 0, 1, 1, 32'd40);
    for (int i = 0; i < 3; i++) tick();
    chk("stall_pc",  {20'd0, address_imem}, 32'd20);
    chk("stall_cnt", instr_count,           cnt_before);
    chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    drive(0, 0, 0, 1, 0, 32'd40);
    tick();
    chk("release_pc",  {20'd0, address_imem}, 32'd40);
    chk("release_cnt", instr_count,           cnt_before + 32'd1);

    // Jump-to-self halts; only reset exits.
    jump_to(12'd7);
    cnt_before = instr_count;
    drive(0, 0, 0, 1, 0, 32'd7);
    tick();
    drive(0, 1, 1, 1, 0, 32'd99);
    for (int i = 0; i < 4; i++) tick();
    chk("halt_pc",     {20'd0, address_imem}, 32'd7);
    chk("halt_flag",   {31'd0, halted},       32'd1);
    chk("halt_valid",  {31'd0, instr_valid},  32'd0);
    chk("halt_cnt",    instr_count,           cnt_before + 32'd1);
    drive(1, 0, 0, 0, 0, 32'd0);
    tick();
    chk("unhalt_pc",     {20'd0, address_imem}, 32'd0);
    chk("unhalt_halted", {31'd0, halted},       32'd0);
    chk("unhalt_cnt",    instr_count,           32'd0);

    // Reset during a stall, then BR/JP asserted during BOOT are ignored.
    drive(0, 0, 0, 0, 0, 32'd0);
    tick();
    jump_to(12'd30);
    drive(0, 0, 0, 0, 1, 32'd0);
    tick();
    chk("stall30_pc", {20'd0, address_imem}, 32'd30);
    drive(1, 0, 0, 0, 1, 32'd0);
    tick();
    chk("midstall_rst_pc",    {20'd0, address_imem}, 32'd0);
    chk("midstall_rst_valid", {31'd0, instr_valid},  32'd0);
    drive(0, 1, 1, 1, 0, 32'd55);
    tick();
    chk("boot_ignore_pc",  {20'd0, address_imem}, 32'd0);
    chk("boot_ignore_cnt", instr_count,           32'd0);
    drive(0, 0, 0, 0, 0, 32'd0);
    tick();
    chk("post_boot_pc", {20'd0, address_imem}, 32'd1);

    if (sb.size() != 0) chk("sb_drain", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
